// File: rtl/move_command_tx_if.sv
// Command/status bundle between path_math-side logic and the serial
// move-command transmitter.
interface move_command_tx_if;
    logic        start;
    logic        abort;
    logic [4:0]  needed_orientation;
    logic [11:0] move_command;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output abort,
        output needed_orientation,
        output move_command,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  needed_orientation,
        input  move_command,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/move_command_tx.sv
// Serializes a latched {orientation, move} command as a 20-bit UART-style frame,
// repeated REPEATS times with idle-high gaps, then pulses done.
module move_command_tx #(
    parameter int BIT_TICKS = 2812,
    parameter int GAP_TICKS = 27000,
    parameter int REPEATS   = 3
) (
    input logic              clock,
    input logic              reset,
    move_command_tx_if.slave bus
);
    localparam int MAX_TICKS = (BIT_TICKS > GAP_TICKS) ? BIT_TICKS : GAP_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int REP_W     = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEATS - 1);
    localparam logic [4:0]        STOP_BIT = 5'd19;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_next;
    logic [4:0]        bit_idx;
    logic [4:0]        bit_next;
    logic [REP_W-1:0]  rep;
    logic [REP_W-1:0]  rep_next;
    logic [16:0]       payload;
    logic [16:0]       payload_next;
    logic [19:0]       frame_next;
    logic              accept;
    logic              tx_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              tx_next;
    logic              busy_next;
    logic              done_next;

    // Frame bit 0 is the start bit; payload bit 0 is orientation LSB.
    function automatic logic [19:0] build_frame(input logic [16:0] data);
        return {1'b1, ^data, data, 1'b0};
    endfunction

    always_comb begin
        state_next   = state;
        tick_next    = tick;
        bit_next     = bit_idx;
        rep_next     = rep;
        payload_next = payload;
        accept       = bus.start && !bus.abort && (state == IDLE || state == DONE);

        unique case (state)
            IDLE: begin
                state_next = IDLE;
            end
            SEND: begin
                if (tick == BIT_LAST) begin
                    tick_next = '0;
                    if (bit_idx == STOP_BIT) begin
                        if (rep == REP_LAST) begin
                            state_next = DONE;
                        end else begin
                            rep_next   = rep + 1'b1;
                            state_next = GAP;
                        end
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            GAP: begin
                if (tick == GAP_LAST) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = SEND;
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A start in the DONE cycle chains straight into the next send.
        if (accept) begin
            state_next   = SEND;
            payload_next = {bus.move_command, bus.needed_orientation};
            tick_next    = '0;
            bit_next     = '0;
            rep_next     = '0;
        end

        if (bus.abort && state != IDLE) begin
            state_next = IDLE;
            tick_next  = '0;
            bit_next   = '0;
            rep_next   = '0;
        end

        // Outputs are decoded from the next state so they register with it.
        frame_next = build_frame(payload_next);
        tx_next    = (state_next == SEND) ? frame_next[bit_next] : 1'b1;
        busy_next  = (state_next == SEND) || (state_next == GAP);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            rep      <= '0;
            payload  <= '0;
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            tick     <= tick_next;
            bit_idx  <= bit_next;
            rep      <= rep_next;
            payload  <= payload_next;
            tx_reg   <= tx_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign bus.tx   = tx_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_move_command_tx.sv
// Scoreboard bench for move_command_tx: two instances (REPEATS=1 and REPEATS=3)
// share stimulus; a frame-level model predicts tx/busy/done for every cycle.
module tb_move_command_tx;
    localparam int BT = 4;
    localparam int GT = 10;

    logic clock;
    logic reset;

    move_command_tx_if bus1 ();
    move_command_tx_if bus3 ();

    move_command_tx #(.BIT_TICKS(BT), .GAP_TICKS(GT), .REPEATS(1)) dut1 (
        .clock(clock),
        .reset(reset),
        .bus  (bus1)
    );

    move_command_tx #(.BIT_TICKS(BT), .GAP_TICKS(GT), .REPEATS(3)) dut3 (
        .clock(clock),
        .reset(reset),
        .bus  (bus3)
    );

    // Expected {tx, busy, done} per future cycle; empty queue means idle.
    logic [2:0] q1[$];
    logic [2:0] q3[$];
    logic [2:0] e1;
    logic [2:0] e3;
    int checks = 0;
    int passed = 0;
    bit mon_en = 0;

    initial begin
        clock = 1'b0;
        #30;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, required %0h at t=%0t", name, got, want, $time);
    endtask

    function automatic logic frame_bit(input logic [4:0] o, input logic [11:0] m, input int b);
        if (b == 0) return 1'b0;
        if (b <= 5) return o[b-1];
        if (b <= 17) return m[b-6];
        if (b == 18) return ^{o, m};
        return 1'b1;
    endfunction

    task automatic push(input int d, input logic [2:0] v);
        if (d == 0) q1.push_back(v);
        else q3.push_back(v);
    endtask

    task automatic model_accept(input int d, input int reps, input logic [4:0] o, input logic [11:0] m);
        for (int r = 0; r < reps; r++) begin
            for (int b = 0; b < 20; b++)
                for (int t = 0; t < BT; t++) push(d, {frame_bit(o, m, b), 1'b1, 1'b0});
            if (r < reps - 1)
                for (int t = 0; t < GT; t++) push(d, 3'b110);
        end
        push(d, 3'b101);
    endtask

    task automatic drive(input logic st, input logic ab, input logic [4:0] o, input logic [11:0] m);
        bus1.start = st; bus1.abort = ab; bus1.needed_orientation = o; bus1.move_command = m;
        bus3.start = st; bus3.abort = ab; bus3.needed_orientation = o; bus3.move_command = m;
        if (ab) begin
            q1.delete();
            q3.delete();
        end else if (st) begin
            if (q1.size() == 0) model_accept(0, 1, o, m);
            if (q3.size() == 0) model_accept(1, 3, o, m);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            tick();
            drive(1'b0, 1'b0, 5'($urandom), 12'($urandom));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 3000) begin
            tick();
            drive(1'b0, 1'b0, 5'($urandom), 12'($urandom));
            n++;
        end
        check(name, 32'(q1.size() + q3.size()), 32'd0);
    endtask

    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            e1 = (q1.size() != 0) ? q1.pop_front() : 3'b100;
            e3 = (q3.size() != 0) ? q3.pop_front() : 3'b100;
            check("dut1_tx_busy_done", 32'({bus1.tx, bus1.busy, bus1.done}), 32'(e1));
            check("dut3_tx_busy_done", 32'({bus3.tx, bus3.busy, bus3.done}), 32'(e3));
        end
    end

    initial begin
        int n;
        drive(1'b0, 1'b0, 5'd0, 12'd0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_no_clock_dut1", 32'({bus1.tx, bus1.busy, bus1.done}), 32'(3'b100));
        check("reset_no_clock_dut3", 32'({bus3.tx, bus3.busy, bus3.done}), 32'(3'b100));
        #8 reset = 1'b1;
        #2;
        check("after_release_dut1", 32'({bus1.tx, bus1.busy, bus1.done}), 32'(3'b100));
        check("after_release_dut3", 32'({bus3.tx, bus3.busy, bus3.done}), 32'(3'b100));
        mon_en = 1'b1;

        // Single and repeated frames with the reference payload.
        idle_cycles(3);
        tick();
        drive(1'b1, 1'b0, 5'h09, 12'h730);
        drain("t23_drain");
        idle_cycles(3);

        // Start while busy is ignored; start in DONE of the 1-repeat unit is taken.
        tick();
        drive(1'b1, 1'b0, 5'h09, 12'h730);
        idle_cycles(20);
        tick();
        drive(1'b1, 1'b0, 5'h01, 12'h122);
        n = 0;
        while (n < 200) begin
            tick();
            if (q1.size() == 0) break;
            drive(1'b0, 1'b0, 5'($urandom), 12'($urandom));
            n++;
        end
        drive(1'b1, 1'b0, 5'h01, 12'h122);
        check("t4_done_reached", 32'(n < 200), 32'd1);
        drain("t4_drain");

        // Abort at bit 7 of the second repeat, then restart one cycle later.
        tick();
        drive(1'b1, 1'b0, 5'($urandom), 12'($urandom));
        idle_cycles(120);
        tick();
        drive(1'b0, 1'b1, 5'($urandom), 12'($urandom));
        tick();
        drive(1'b1, 1'b0, 5'h15, 12'hA5C);
        drain("t5_drain");

        // Asynchronous reset in the middle of a bit.
        tick();
        drive(1'b1, 1'b0, 5'h0E, 12'h3C7);
        idle_cycles(30);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async_reset_dut1", 32'({bus1.tx, bus1.busy, bus1.done}), 32'(3'b100));
        check("async_reset_dut3", 32'({bus3.tx, bus3.busy, bus3.done}), 32'(3'b100));
        q1.delete();
        q3.delete();
        idle_cycles(2);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'($urandom), 12'($urandom));
        idle_cycles(20);

        // Random mix of starts, aborts and payload churn.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 63));
            tick();
            drive(r < 8, r == 63, 5'($urandom), 12'($urandom));
        end
        drain("random_drain");
        idle_cycles(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
